multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle RV32I-subset datapath (lw, sw, R-type ALU,
// I-type ALU, jal, beq). A Moore FSM steps each instruction through
// fetch/decode/execute/writeback. ALU-op and immediate-format selects are
// decoded combinationally from the instruction fields.
//
// Compile-time option:
//   ILLEGAL_OP_TRAP_EN  defined   : unsupported opcode in DECODE enters ERROR.
//                                   ERROR drives IllegalOp=1 and holds every
//                                   strobe low until reset.
//                       undefined : unsupported opcode retires as a 2-cycle nop
//                                   and IllegalOp is tied 0.
//
// Ports:
//   clk         in   1  clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   op          in   7  instr[6:0]
//   funct3      in   3  instr[14:12]
//   funct7b5    in   1  instr[30]
//   Zero        in   1  ALU zero flag
//   PCWrite     out  1  PC load enable
//   AdrSrc      out  1  memory address select (0 = PC, 1 = ALU result)
//   MemWrite    out  1  data memory write strobe
//   IRWrite     out  1  instruction register load enable
//   RegWrite    out  1  register file write strobe
//   ResultSrc   out  2  result mux select
//   ALUSrcA     out  2  ALU operand A select
//   ALUSrcB     out  2  ALU operand B select
//   ImmSrc      out  2  immediate format select
//   ALUControl  out  3  ALU operation
//   IllegalOp   out  1  unsupported-opcode flag
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | load IR from memory[PC], PC <= PC + 4
// DECODE   | read registers, precompute branch/jump target (old PC + imm)
// MEMADR   | compute load/store effective address rs1 + imm
// MEMREAD  | read data memory at the computed address
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECUTER | ALU on rs1, rs2
// EXECUTEI | ALU on rs1, imm
// ALUWB    | write ALU result to rd
// JAL      | PC <= target, compute return address PC + 4
// BEQ      | compare rs1 - rs2, take target when Zero
// ERROR    | trapped on unsupported opcode; all strobes low until reset

module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_alu_op;

    // State register: reset forces FETCH asynchronously, so the reset-time
    // outputs are simply the FETCH outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_EXECUTER;
                    OP_ITYP:      w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      w_next = S_ERROR;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_ERROR:    w_next = S_ERROR;
`else
            S_ERROR:    w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore outputs; anything not set in a state stays 0.
    always_comb begin
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcA     = 2'b00;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Zero only matters while the branch compare is on the ALU.
    assign PCWrite = w_pc_update | (w_branch & Zero);

`ifdef ILLEGAL_OP_TRAP_EN
    assign IllegalOp = (r_state == S_ERROR);
`else
    assign IllegalOp = 1'b0;
`endif

    // ALU decoder. Only R-type (op[5]=1) with funct7b5 turns funct3=000 into
    // sub; addi keeps add whatever instr[30] happens to hold.
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format from opcode alone, valid in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_ITYP: ImmSrc = 2'b00;
            OP_SW:          ImmSrc = 2'b01;
            OP_BEQ:         ImmSrc = 2'b10;
            OP_JAL:         ImmSrc = 2'b11;
            default:        ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_JAL, T_BEQ, T_ERROR
    } tst_e;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    tst_e seq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
    //  ALUSrcB, ImmSrc, ALUControl, IllegalOp}
    logic [16:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp};

    // Expected outputs for one state, straight from the per-state table.
    // imm and ac_exec are hand-computed per instruction by the caller.
    function automatic logic [16:0] exp_vec(tst_e st, logic [1:0] imm,
                                            logic [2:0] ac_exec, logic z);
        logic pcw, adr, memw, irw, regw, ill;
        logic [1:0] rs, a, b;
        logic [2:0] ac;
        pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; ill = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; ac = 3'b000;
        case (st)
            T_FETCH:    begin pcw = 1; irw = 1; rs = 2'b10; b = 2'b10; end
            T_DECODE:   begin a = 2'b01; b = 2'b01; end
            T_MEMADR:   begin a = 2'b10; b = 2'b01; end
            T_MEMREAD:  begin adr = 1; end
            T_MEMWB:    begin rs = 2'b01; regw = 1; end
            T_MEMWRITE: begin adr = 1; memw = 1; end
            T_EXECR:    begin a = 2'b10; b = 2'b00; ac = ac_exec; end
            T_EXECI:    begin a = 2'b10; b = 2'b01; ac = ac_exec; end
            T_ALUWB:    begin regw = 1; end
            T_JAL:      begin pcw = 1; a = 2'b01; b = 2'b10; end
            T_BEQ:      begin pcw = z; a = 2'b10; ac = 3'b001; end
            T_ERROR:    begin ill = 1; end
            default:    begin end
        endcase
        return {pcw, adr, memw, irw, regw, rs, a, b, imm, ac, ill};
    endfunction

    // Called at posedge+1: queue what the current state must show, then move
    // to posedge+1 of the next cycle.
    task automatic push_step(tst_e st, logic [1:0] imm, logic [2:0] ac, string name);
        exp_t e;
        e.v    = exp_vec(st, imm, ac, Zero);
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic f7,
                             logic z, logic [1:0] imm, logic [2:0] ac);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int i = 0; i < seq.size(); i++)
            push_step(seq[i], imm, ac, $sformatf("%s_c%0d", name, i + 1));
    endtask

    // Monitor: mid-cycle, compare whatever the scoreboard holds.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (act !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", mon_e.name, act, mon_e.v);
            end
        end
    end

    initial begin
        rst = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk);
        #1;
        push_step(T_FETCH, 2'b00, 3'b000, "reset_hold1");
        op = 7'b0100011; Zero = 1'b1;
        push_step(T_FETCH, 2'b01, 3'b000, "reset_hold2_immsrc");
        rst = 1'b1;

        seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB};
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);

        seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE};
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000);

        seq = '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB};
        run_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 1'b1, 2'b00, 3'b001);
        run_instr("r_add",  7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000);
        run_instr("r_slt",  7'b0110011, 3'b010, 1'b0, 1'b1, 2'b00, 3'b101);
        run_instr("r_or",   7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011);
        run_instr("r_and",  7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010);
        run_instr("r_f3_1", 7'b0110011, 3'b001, 1'b0, 1'b0, 2'b00, 3'b000);

        seq = '{T_FETCH, T_DECODE, T_EXECI, T_ALUWB};
        run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000);
        run_instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b1, 2'b00, 3'b101);
        run_instr("andi",    7'b0010011, 3'b111, 1'b1, 1'b0, 2'b00, 3'b010);

        seq = '{T_FETCH, T_DECODE, T_JAL, T_ALUWB};
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b1, 2'b11, 3'b000);

        seq = '{T_FETCH, T_DECODE, T_BEQ};
        run_instr("beq_taken",    7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000);
        run_instr("beq_nottaken", 7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000);

        // Reset asserted the moment lw reaches MEMREAD; outputs must flip to
        // the reset/FETCH pattern before the next clock edge.
        seq = '{T_FETCH, T_DECODE, T_MEMADR};
        run_instr("lw_rst", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);
        rst = 1'b0;
        push_step(T_FETCH, 2'b00, 3'b000, "midmemread_rst1");
        push_step(T_FETCH, 2'b00, 3'b000, "midmemread_rst2");
        rst = 1'b1;

        seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB};
        run_instr("lw_after_rst", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);

`ifdef ILLEGAL_OP_TRAP_EN
        seq = '{T_FETCH, T_DECODE};
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b1, 2'b00, 3'b000);
        for (int i = 0; i < 10; i++)
            push_step(T_ERROR, 2'b00, 3'b000, $sformatf("error_hold%0d", i + 1));
        rst = 1'b0;
        push_step(T_FETCH, 2'b00, 3'b000, "error_rst");
        rst = 1'b1;
`else
        seq = '{T_FETCH, T_DECODE};
        run_instr("illegal_nop", 7'b1111111, 3'b000, 1'b0, 1'b1, 2'b00, 3'b000);
`endif

        seq = '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB};
        run_instr("r_sub_final", 7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
